// File: rtl/divider_pkg.sv
// Constants and types shared by the restoring-divider datapath stages.
package divider_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int MODE_GATE   = 0;
  localparam int MODE_SELECT = 1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/masked_select_stage_if.sv
// Handshake bundle for masked_select_stage: operand input side and result output side.
interface masked_select_stage_if
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_flag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_flag;

  modport master (
    output in_valid, in_a, in_b, in_flag, out_ready,
    input  in_ready, out_valid, out_data, out_flag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_flag, out_ready,
    output in_ready, out_valid, out_data, out_flag
  );

endinterface

// File: rtl/masked_select_stage_flag_mask_logic.sv
// Combinational gate/select datapath: y = a & {flag} (gate) or flag ? a : b (select).
module flag_mask_logic
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int MODE  = MODE_GATE
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flag,
  output logic [WIDTH-1:0] y
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (MODE == MODE_SELECT) begin : g_sel
      assign y[gi] = flag ? a[gi] : b[gi];
    end else begin : g_gate
      assign y[gi] = a[gi] & flag;
    end
  end

  // Gate mode never looks at b; the reduction only marks it deliberately unused.
  if (MODE != MODE_SELECT) begin : g_b_pruned
    logic unused_b;
    assign unused_b = ^b;
  end

endmodule

// File: rtl/masked_select_stage.sv
// Registered flag gate/select stage with a 2-entry skid buffer and a saturating
// count of accepted transactions whose flag was low.
module masked_select_stage
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int MODE  = MODE_GATE,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  masked_select_stage_if.slave bus,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   gated_cnt
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "masked_select_stage: WIDTH=%0d outside 1..64", WIDTH);
  end
  if (MODE != MODE_GATE && MODE != MODE_SELECT) begin : g_bad_mode
    $fatal(1, "masked_select_stage: MODE=%0d is not 0 or 1", MODE);
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $fatal(1, "masked_select_stage: CNT_W=%0d must be positive", CNT_W);
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] res;

  flag_mask_logic #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_mask (
    .a    (bus.in_a),
    .b    (bus.in_b),
    .flag (bus.in_flag),
    .y    (res)
  );

  occ_e             occ_q,      occ_d;
  logic [WIDTH-1:0] m_data_q,   m_data_d;
  logic             m_flag_q,   m_flag_d;
  logic [WIDTH-1:0] s_data_q,   s_data_d;
  logic             s_flag_q,   s_flag_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = (occ_q != OCC_EMPTY) & bus.out_ready;

  always_comb begin
    occ_d    = occ_q;
    m_data_d = m_data_q;
    m_flag_d = m_flag_q;
    s_data_d = s_data_q;
    s_flag_d = s_flag_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (in_xfer) begin
          m_data_d = res;
          m_flag_d = bus.in_flag;
          occ_d    = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (in_xfer && out_xfer) begin
          m_data_d = res;
          m_flag_d = bus.in_flag;
        end else if (in_xfer) begin
          s_data_d = res;
          s_flag_d = bus.in_flag;
          occ_d    = OCC_TWO;
        end else if (out_xfer) begin
          occ_d    = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (out_xfer) begin
          m_data_d = s_data_q;
          m_flag_d = s_flag_q;
          occ_d    = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    // in_ready is a flop so upstream never sees a combinational path from out_ready.
    in_ready_d = (occ_d != OCC_TWO);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (in_xfer && !bus.in_flag && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= OCC_EMPTY;
      m_data_q   <= '0;
      m_flag_q   <= 1'b0;
      s_data_q   <= '0;
      s_flag_q   <= 1'b0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      m_data_q   <= m_data_d;
      m_flag_q   <= m_flag_d;
      s_data_q   <= s_data_d;
      s_flag_q   <= s_flag_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (occ_q != OCC_EMPTY);
  assign bus.out_data  = m_data_q;
  assign bus.out_flag  = m_flag_q;
  assign gated_cnt     = cnt_q;

endmodule
